apb_master_arbiter: RTL and testbench
=====================================

Name: apb_master_arbiter

Overview:
- Shares one APB master port among NUM_REQ internal requesters, such as the I2S DMA/config engines and the debug host.
- Arbitrates round-robin and sequences each transfer through the APB SETUP and ACCESS phases.
- Returns read data and error to the winning requester.
- Bounds every access with an optional pready timeout.

Parameters:
APB_ADDR_WIDTH, 32, paddr / req_addr element width
APB_DATA_WIDTH, 32, pwdata / prdata / req_wdata / rsp_rdata element width
NUM_REQ, 2, number of requesters (2..8)
TIMEOUT, 16, maximum ACCESS cycles waiting for pready; 0 = no timeout

Ports:
pclk  in  1  APB clock, rising edge
preset  in  1  asynchronous reset, active-high
req_valid  in  NUM_REQ  request per requester; held with payload until its rsp_valid
req_write  in  NUM_REQ  1 = write, 0 = read
req_addr  in  NUM_REQ*APB_ADDR_WIDTH  packed addresses; requester i at [i*AW +: AW]
req_wdata  in  NUM_REQ*APB_DATA_WIDTH  packed write data
rsp_valid  out  NUM_REQ  one-cycle completion pulse to the owning requester
rsp_rdata  out  APB_DATA_WIDTH  read data; valid while any rsp_valid is high
rsp_err  out  1  pslverr or timeout; valid with rsp_valid
timeout_pulse  out  1  one-cycle pulse when an access is aborted by timeout
paddr  out  APB_ADDR_WIDTH  APB address
psel  out  1  APB select
penable  out  1  APB enable
pwrite  out  1  APB direction
pwdata  out  APB_DATA_WIDTH  APB write data
prdata  in  APB_DATA_WIDTH  APB read data
pready  in  1  APB ready
pslverr  in  1  APB slave error

Behaviour:
- One clock domain: pclk.
- preset is asynchronous, active-high. Asserting it at any time, including mid-transfer, forces immediately:
  - state=IDLE, psel=0, penable=0, pwrite=0, paddr=0, pwdata=0
  - rsp_valid=0, rsp_rdata=0, rsp_err=0, timeout_pulse=0
  - rr_ptr=0, timeout counter=0
- All outputs are registered.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - If any req_valid is high, grant the first set bit searching from rr_ptr upward, wrapping at NUM_REQ.
  - Latch owner index, req_addr, req_write and req_wdata into paddr/pwrite/pwdata.
  - Next state SETUP.
  - With no request, stay in IDLE; paddr/pwrite/pwdata keep their last values.
- SETUP: psel=1, penable=0; always exactly one cycle; pready is ignored. Next state ACCESS.
- ACCESS:
  - psel=1, penable=1; paddr/pwrite/pwdata stay stable.
  - The counter increments each cycle pready=0.
  - On pready=1: capture prdata (reads only, else 0) into rsp_rdata and pslverr into rsp_err. Next state RESP.
  - If TIMEOUT>0 and the counter reaches TIMEOUT with pready still 0: rsp_rdata=0, rsp_err=1, timeout_pulse=1 for one cycle. Next state RESP.
  - pready on the same cycle as the counter reaching TIMEOUT counts as normal completion.
- RESP:
  - psel=0, penable=0; rsp_valid[owner]=1 for this cycle only.
  - rr_ptr = (owner+1) mod NUM_REQ; counter cleared. Next state IDLE.
  - The requester must drop or refresh req_valid by the next edge.
- Transfer latency with zero wait states: request sampled in IDLE (cycle 0), SETUP at cycle 1, ACCESS at 2, rsp_valid at 3.
  - Back-to-back transfers therefore take 4 cycles each.
- Requests that change or drop while not granted are legal and are not latched.
- A requester deasserting req_valid mid-transfer does not abort the transfer.
- Counter width is $clog2(TIMEOUT+1); the counter saturates and never wraps.

Test Plan:
- Reset mid-transfer: preset asserted during ACCESS -> psel/penable drop to 0 in the same cycle with no clock; after release, state is IDLE and rr_ptr=0.
- Single write, zero wait: req0 write addr 0x10, data 0xA5A5_0001, pready tied 1 -> SETUP at c1 (psel=1, penable=0), ACCESS at c2, rsp_valid=01 at c3, rsp_err=0.
- Read with waits: req1 read 0x24, pready low 3 cycles then high with prdata=0xDEAD_BEEF -> psel+penable held 4 cycles with paddr stable; rsp_valid=10, rsp_rdata=0xDEADBEEF.
- Round-robin: req0 and req1 held high continuously for 4 transfers -> grants alternate 0,1,0,1; neither requester is starved.
- Slave error: pslverr=1 with pready=1 on a read -> rsp_err=1, timeout_pulse=0.
- Timeout: TIMEOUT=16, pready stuck 0 -> abort after 16 ACCESS cycles, timeout_pulse=1, rsp_err=1, rsp_rdata=0. Next request proceeds normally.

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ
// requesters, with optional pready timeout on the ACCESS phase.
module apb_master_arbiter #(
  parameter int APB_ADDR_WIDTH = 32,
  parameter int APB_DATA_WIDTH = 32,
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT        = 16
) (
  input  logic                              pclk,
  input  logic                              preset,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0]                req_write,
  input  logic [NUM_REQ*APB_ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*APB_DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]                rsp_valid,
  output logic [APB_DATA_WIDTH-1:0]         rsp_rdata,
  output logic                              rsp_err,
  output logic                              timeout_pulse,
  output logic [APB_ADDR_WIDTH-1:0]         paddr,
  output logic                              psel,
  output logic                              penable,
  output logic                              pwrite,
  output logic [APB_DATA_WIDTH-1:0]         pwdata,
  input  logic [APB_DATA_WIDTH-1:0]         prdata,
  input  logic                              pready,
  input  logic                              pslverr
);

  localparam int AW = APB_ADDR_WIDTH;
  localparam int DW = APB_DATA_WIDTH;
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TO_EN = (TIMEOUT > 0);
  localparam logic [CW-1:0] CNT_MAX =
    CW'((TIMEOUT > 0) ? TIMEOUT : 1);
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } state_e;

  state_e            state_q, state_d;
  logic [IW-1:0]     owner_q, owner_d;
  logic [IW-1:0]     rr_q, rr_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DW-1:0]     pwdata_q, pwdata_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic [NUM_REQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]     rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              tmo_q, tmo_d;

  logic              gnt_found;
  logic [IW-1:0]     gnt_idx;
  logic [IW:0]       scan;

  // Walk downward so the lowest offset from rr_q wins last.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan      = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      scan = {1'b0, rr_q} + (IW+1)'(k);
      if (scan >= (IW+1)'(NUM_REQ)) begin
        scan = scan - (IW+1)'(NUM_REQ);
      end
      if (req_valid[scan[IW-1:0]]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan[IW-1:0];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    rr_d        = rr_q;
    cnt_d       = cnt_q;
    paddr_d     = paddr_q;
    pwrite_d    = pwrite_q;
    pwdata_d    = pwdata_q;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    tmo_d       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt_found) begin
          owner_d  = gnt_idx;
          paddr_d  = req_addr[gnt_idx*AW +: AW];
          pwrite_d = req_write[gnt_idx];
          pwdata_d = req_wdata[gnt_idx*DW +: DW];
          psel_d   = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        psel_d    = 1'b1;
        penable_d = 1'b1;
        state_d   = ACCESS;
      end
      ACCESS: begin
        if (pready) begin
          rsp_rdata_d          = pwrite_q ? '0 : prdata;
          rsp_err_d            = pslverr;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else if (TO_EN && cnt_q == CNT_LAST) begin
          rsp_rdata_d          = '0;
          rsp_err_d            = 1'b1;
          tmo_d                = 1'b1;
          rsp_valid_d[owner_q] = 1'b1;
          state_d              = RESP;
        end else begin
          psel_d    = 1'b1;
          penable_d = 1'b1;
          if (cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      RESP: begin
        cnt_d   = '0;
        state_d = IDLE;
        if (owner_q == IW'(NUM_REQ - 1)) begin
          rr_d = '0;
        end else begin
          rr_d = owner_q + IW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      rr_q        <= '0;
      cnt_q       <= '0;
      paddr_q     <= '0;
      pwrite_q    <= 1'b0;
      pwdata_q    <= '0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      tmo_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      rr_q        <= rr_d;
      cnt_q       <= cnt_d;
      paddr_q     <= paddr_d;
      pwrite_q    <= pwrite_d;
      pwdata_q    <= pwdata_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      tmo_q       <= tmo_d;
    end
  end

  assign paddr         = paddr_q;
  assign pwrite        = pwrite_q;
  assign pwdata        = pwdata_q;
  assign psel          = psel_q;
  assign penable       = penable_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign rsp_err       = rsp_err_q;
  assign timeout_pulse = tmo_q;

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Bench for apb_master_arbiter: directed scenarios plus random traffic,
// all checked each cycle against a transaction-level reference model.
module tb_apb_master_arbiter;

  localparam int NR = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;

  logic             pclk = 1'b0;
  logic             preset = 1'b1;
  logic [NR-1:0]    req_valid = '0;
  logic [NR-1:0]    req_write = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*DW-1:0] req_wdata = '0;
  logic [NR-1:0]    rsp_valid;
  logic [DW-1:0]    rsp_rdata;
  logic             rsp_err;
  logic             timeout_pulse;
  logic [AW-1:0]    paddr;
  logic             psel;
  logic             penable;
  logic             pwrite;
  logic [DW-1:0]    pwdata;
  logic [DW-1:0]    prdata = '0;
  logic             pready = 1'b1;
  logic             pslverr = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: phase 0 idle, 1 select, 2 enable, 3 respond
  int            m_stage = 0;
  int            m_owner = 0;
  int            m_rr = 0;
  int            m_wait = 0;
  logic [AW-1:0] m_addr = '0;
  logic          m_write = 1'b0;
  logic [DW-1:0] m_wdata = '0;
  logic [DW-1:0] m_rdata = '0;
  logic          m_err = 1'b0;
  logic          m_tmo = 1'b0;

  apb_master_arbiter #(
    .APB_ADDR_WIDTH(AW),
    .APB_DATA_WIDTH(DW),
    .NUM_REQ(NR),
    .TIMEOUT(TO)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .req_valid(req_valid),
    .req_write(req_write),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err),
    .timeout_pulse(timeout_pulse),
    .paddr(paddr),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .prdata(prdata),
    .pready(pready),
    .pslverr(pslverr)
  );

  always #5 pclk = ~pclk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s t=%0t act=%0h exp=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic model_next();
    if (preset) begin
      m_stage = 0; m_owner = 0; m_rr = 0; m_wait = 0;
      m_addr = '0; m_write = 1'b0; m_wdata = '0;
      m_rdata = '0; m_err = 1'b0; m_tmo = 1'b0;
      return;
    end
    case (m_stage)
      0: begin
        for (int k = 0; k < NR; k++) begin
          int i;
          i = (m_rr + k) % NR;
          if (req_valid[i]) begin
            m_owner = i;
            m_addr  = req_addr[i*AW +: AW];
            m_write = req_write[i];
            m_wdata = req_wdata[i*DW +: DW];
            m_stage = 1;
            break;
          end
        end
      end
      1: begin
        m_stage = 2;
        m_wait  = 0;
        m_tmo   = 1'b0;
      end
      2: begin
        if (pready) begin
          m_rdata = m_write ? '0 : prdata;
          m_err   = pslverr;
          m_stage = 3;
        end else begin
          m_wait++;
          if (TO > 0 && m_wait == TO) begin
            m_rdata = '0;
            m_err   = 1'b1;
            m_tmo   = 1'b1;
            m_stage = 3;
          end
        end
      end
      default: begin
        m_rr    = (m_owner + 1) % NR;
        m_stage = 0;
      end
    endcase
  endtask

  task automatic compare();
    logic [NR-1:0] ev;
    ev = (m_stage == 3) ? NR'(1 << m_owner) : '0;
    chk("psel", psel, m_stage == 1 || m_stage == 2);
    chk("penable", penable, m_stage == 2);
    chk("paddr", paddr, m_addr);
    chk("pwrite", pwrite, m_write);
    chk("pwdata", pwdata, m_wdata);
    chk("rsp_valid", rsp_valid, ev);
    chk("timeout_pulse", timeout_pulse, m_stage == 3 && m_tmo);
    if (ev != '0) begin
      chk("rsp_rdata", rsp_rdata, m_rdata);
      chk("rsp_err", rsp_err, m_err);
    end
  endtask

  task automatic tick();
    model_next();
    @(posedge pclk);
    @(negedge pclk);
    compare();
  endtask

  task automatic set_req(input int i, input logic w,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_write[i]        = w;
    req_addr[i*AW +: AW] = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  initial begin
    int g[$];
    int stuck;
    stuck = 0;

    // Reset state
    tick();
    tick();
    chk("rst_psel", psel, 0);
    chk("rst_penable", penable, 0);
    chk("rst_paddr", paddr, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    preset = 1'b0;
    tick();

    // Single write, zero wait
    set_req(0, 1'b1, 32'h10, 32'hA5A5_0001);
    req_valid = 2'b01;
    pready = 1'b1;
    tick();
    chk("w_setup_psel", psel, 1);
    chk("w_setup_pen", penable, 0);
    chk("w_paddr", paddr, 32'h10);
    chk("w_pwdata", pwdata, 32'hA5A5_0001);
    req_valid = 2'b00;
    tick();
    chk("w_access_pen", penable, 1);
    tick();
    chk("w_rsp_valid", rsp_valid, 2'b01);
    chk("w_rsp_err", rsp_err, 0);
    tick();

    // Read with three wait states
    set_req(1, 1'b0, 32'h24, 32'h0);
    req_valid = 2'b10;
    pready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("r_psel", psel, 1);
      chk("r_pen", penable, 1);
      chk("r_paddr", paddr, 32'h24);
      if (i == 3) begin
        pready = 1'b1;
        prdata = 32'hDEAD_BEEF;
      end
      tick();
    end
    chk("r_rsp_valid", rsp_valid, 2'b10);
    chk("r_rdata", rsp_rdata, 32'hDEAD_BEEF);
    req_valid = 2'b00;
    tick();

    // Round-robin with both requesters held
    set_req(0, 1'b1, 32'h100, 32'h1);
    set_req(1, 1'b0, 32'h200, 32'h2);
    req_valid = 2'b11;
    for (int c = 0; c < 16; c++) begin
      tick();
      for (int i = 0; i < NR; i++) begin
        if (rsp_valid[i]) g.push_back(i);
      end
    end
    req_valid = 2'b00;
    chk("rr_count", g.size(), 4);
    for (int k = 0; k < g.size() && k < 4; k++) begin
      chk("rr_grant", g[k], k % 2);
    end

    // Slave error on a read
    set_req(0, 1'b0, 32'h30, 32'h0);
    req_valid = 2'b01;
    pslverr = 1'b1;
    prdata = 32'h1234;
    tick();
    tick();
    tick();
    chk("e_rsp_valid", rsp_valid, 2'b01);
    chk("e_err", rsp_err, 1);
    chk("e_tmo", timeout_pulse, 0);
    chk("e_rdata", rsp_rdata, 32'h1234);
    req_valid = 2'b00;
    pslverr = 1'b0;
    tick();

    // Asynchronous reset in ACCESS, pointer sitting at 1
    set_req(0, 1'b1, 32'h60, 32'h66);
    set_req(1, 1'b1, 32'h70, 32'h77);
    req_valid = 2'b01;
    pready = 1'b0;
    tick();
    tick();
    tick();
    chk("ar_pen_before", penable, 1);
    #1 preset = 1'b1;
    #1;
    chk("ar_psel", psel, 0);
    chk("ar_pen", penable, 0);
    chk("ar_paddr", paddr, 0);
    tick();
    preset = 1'b0;
    req_valid = 2'b11;
    pready = 1'b1;
    tick();
    chk("ar_rr0_paddr", paddr, 32'h60);
    req_valid = 2'b00;
    tick();
    tick();
    tick();

    // Timeout with pready stuck low
    set_req(0, 1'b0, 32'h40, 32'h0);
    req_valid = 2'b01;
    pready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < TO; i++) begin
      chk("t_pen", penable, 1);
      tick();
    end
    chk("t_rsp_valid", rsp_valid, 2'b01);
    chk("t_tmo", timeout_pulse, 1);
    chk("t_err", rsp_err, 1);
    chk("t_rdata", rsp_rdata, 0);
    req_valid = 2'b00;
    pready = 1'b1;
    tick();

    // Normal transfer after timeout
    set_req(1, 1'b1, 32'h50, 32'h55);
    req_valid = 2'b10;
    tick();
    chk("n_paddr", paddr, 32'h50);
    req_valid = 2'b00;
    tick();
    tick();
    chk("n_rsp_valid", rsp_valid, 2'b10);
    chk("n_err", rsp_err, 0);
    chk("n_tmo", timeout_pulse, 0);
    tick();

    // Random traffic
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NR; i++) begin
        req_valid[i] = ($urandom_range(0, 9) < 6);
        if ($urandom_range(0, 3) == 0) begin
          set_req(i, 1'($urandom_range(0, 1)), $urandom, $urandom);
        end
      end
      if (stuck == 0 && $urandom_range(0, 99) < 3) begin
        stuck = $urandom_range(10, 25);
      end
      if (stuck > 0) begin
        pready = 1'b0;
        stuck--;
      end else begin
        pready = ($urandom_range(0, 3) != 0);
      end
      pslverr = ($urandom_range(0, 9) == 0);
      prdata = $urandom;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
